// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control decoder with a radix-2 multiply/divide sequencer and HI/LO registers.
// Define SIGNED_MULDIV_EN to support signed MULT/DIV; otherwise they decode as illegal.
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic             issue,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [3:0]       alu_ctrl,
  output logic             illegal,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
`ifdef SIGNED_MULDIV_EN
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
`endif

  typedef enum logic [3:0] {
    AC_AND  = 4'b0000,
    AC_OR   = 4'b0001,
    AC_ADD  = 4'b0010,
    AC_SUB  = 4'b0011,
    AC_SLT  = 4'b0100,
    AC_NOR  = 4'b0101,
    AC_XOR  = 4'b0110,
    AC_SLL  = 4'b0111,
    AC_SRL  = 4'b1000,
    AC_SRA  = 4'b1001,
    AC_MFHI = 4'b1010,
    AC_MFLO = 4'b1011,
    AC_NONE = 4'b1110,
    AC_BAD  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  alu_ctrl_e ctrl_dec;
  logic      dec_bad, dec_mul, dec_div, dec_signed, dec_mthi, dec_mtlo, dec_mf;
  logic      hilo_class, start;

  state_e           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  logic [WIDTH-1:0] acc, sreg, opb, a_q;
  logic             op_div, div_zero, neg_q, neg_r;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]     mul_sum, div_trial, div_diff;
  logic [WIDTH-1:0]   acc_step, sreg_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;

  // ---------------------------------------------------------------- decode
  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    ctrl_dec   = AC_BAD;
    dec_bad    = 1'b0;
    dec_mul    = 1'b0;
    dec_div    = 1'b0;
    dec_signed = 1'b0;
    dec_mthi   = 1'b0;
    dec_mtlo   = 1'b0;
    dec_mf     = 1'b0;
    case (alu_op)
      2'b00: ctrl_dec = AC_ADD;
      2'b01: ctrl_dec = AC_SUB;
      2'b10: begin
        case (func)
          F_AND:          ctrl_dec = AC_AND;
          F_OR:           ctrl_dec = AC_OR;
          F_ADD, F_ADDU:  ctrl_dec = AC_ADD;
          F_SUB, F_SUBU:  ctrl_dec = AC_SUB;
          F_SLT:          ctrl_dec = AC_SLT;
          F_NOR:          ctrl_dec = AC_NOR;
          F_XOR:          ctrl_dec = AC_XOR;
          F_SLL:          ctrl_dec = AC_SLL;
          F_SRL:          ctrl_dec = AC_SRL;
          F_SRA:          ctrl_dec = AC_SRA;
          F_MFHI: begin ctrl_dec = AC_MFHI; dec_mf   = 1'b1; end
          F_MFLO: begin ctrl_dec = AC_MFLO; dec_mf   = 1'b1; end
          F_MTHI: begin ctrl_dec = AC_NONE; dec_mthi = 1'b1; end
          F_MTLO: begin ctrl_dec = AC_NONE; dec_mtlo = 1'b1; end
          F_MULTU: begin ctrl_dec = AC_NONE; dec_mul = 1'b1; end
          F_DIVU:  begin ctrl_dec = AC_NONE; dec_div = 1'b1; end
`ifdef SIGNED_MULDIV_EN
          F_MULT: begin ctrl_dec = AC_NONE; dec_mul = 1'b1; dec_signed = 1'b1; end
          F_DIV:  begin ctrl_dec = AC_NONE; dec_div = 1'b1; dec_signed = 1'b1; end
`endif
          default: dec_bad = 1'b1;
        endcase
      end
      default: dec_bad = 1'b1;
    endcase
  end

  assign alu_ctrl   = ctrl_dec;
  assign illegal    = issue & dec_bad;
  assign hilo_class = dec_mul | dec_div | dec_mthi | dec_mtlo | dec_mf;
  assign start      = issue & (dec_mul | dec_div);
  // busy covers the DONE cycle too, so an MFHI/MFLO there waits one more cycle.
  assign stall      = busy & issue & hilo_class;

  // ---------------------------------------------------------------- sequencer FSM
  assign last_step = (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_BUSY;
      S_BUSY:  if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      done  <= (state == S_BUSY) && last_step;
      if (state == S_IDLE) begin
        if (start) cnt <= '0;
        if (issue && dec_mthi) hi <= op_a;
        if (issue && dec_mtlo) lo <= op_a;
      end else if (state == S_BUSY) begin
        if (last_step) begin
          hi <= res_hi;
          lo <= res_lo;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  assign a_mag = (dec_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign b_mag = (dec_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  // NOTE: operand/working registers carry no reset; state gating makes their contents don't-care in IDLE.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      acc      <= '0;
      sreg     <= a_mag;
      opb      <= b_mag;
      a_q      <= op_a;
      op_div   <= dec_div;
      div_zero <= (op_b == '0);
      neg_q    <= dec_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r    <= dec_signed & op_a[WIDTH-1];
    end else if (state == S_BUSY && !last_step) begin
      acc  <= acc_step;
      sreg <= sreg_step;
    end
  end

  // Multiply: acc:sreg is the product, sreg's LSB selects the addend, shift right.
  // Divide: acc is the partial remainder, sreg shifts dividend bits out and quotient bits in.
  always_comb begin
    mul_sum   = {1'b0, acc} + (sreg[0] ? {1'b0, opb} : '0);
    div_trial = {acc, sreg[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opb};
    if (op_div) begin
      if (div_diff[WIDTH]) begin
        acc_step  = div_trial[WIDTH-1:0];
        sreg_step = {sreg[WIDTH-2:0], 1'b0};
      end else begin
        acc_step  = div_diff[WIDTH-1:0];
        sreg_step = {sreg[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step  = mul_sum[WIDTH:1];
      sreg_step = {mul_sum[0], sreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod     = {acc, sreg};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -sreg : sreg;
    rem_fix  = neg_r ? -acc : acc;
    if (!op_div) begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_hi = rem_fix;
      res_lo = quo_fix;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed self-checking bench for alu_ctrl_muldiv at WIDTH=8.
// Exercises decode, MULTU/DIVU latency and results, stalls, MTHI/MTLO and reset abort.
module tb_alu_ctrl_muldiv;

  localparam int W = 8;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk;
  logic         reset;
  logic [1:0]   alu_op;
  logic [5:0]   func;
  logic         issue;
  logic [W-1:0] op_a, op_b;
  logic [3:0]   alu_ctrl;
  logic         illegal, busy, stall, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] m_hi, m_lo;

  alu_ctrl_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_op   (alu_op),
    .func     (func),
    .issue    (issue),
    .op_a     (op_a),
    .op_b     (op_b),
    .alu_ctrl (alu_ctrl),
    .illegal  (illegal),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [3:0] ctrl;
    logic       ill;
  } dec_vec_t;

  dec_vec_t dv [11] = '{
    '{2'b00, 6'b000000, 4'b0010, 1'b0},
    '{2'b01, 6'b000000, 4'b0011, 1'b0},
    '{2'b10, 6'b100101, 4'b0001, 1'b0},
    '{2'b10, 6'b101010, 4'b0100, 1'b0},
    '{2'b10, 6'b111111, 4'b1111, 1'b1},
    '{2'b11, 6'b100000, 4'b1111, 1'b1},
    '{2'b10, 6'b100011, 4'b0011, 1'b0},
    '{2'b10, 6'b000011, 4'b1001, 1'b0},
    '{2'b10, 6'b010000, 4'b1010, 1'b0},
    '{2'b10, 6'b010010, 4'b1011, 1'b0},
    '{2'b10, 6'b100110, 4'b0110, 1'b0}
  };

  // Issue one mul/div and follow it cycle by cycle against fixed latency.
  task automatic run_muldiv(input string tag, input logic [5:0] f,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] exp);
    int   n_done;
    int   done_at;
    logic busy_ok;
    alu_op = 2'b10; func = f; op_a = a; op_b = b; issue = 1'b1;
    step();
    issue = 1'b0; op_a = ~a; op_b = 8'h5A;
    check({tag, "_busy_start"}, busy, 1);
    n_done = 0; done_at = 0; busy_ok = 1'b1;
    for (int c = 1; c <= W + 2; c++) begin
      if (c == 3) begin
        func = F_MFLO; issue = 1'b1; #1;
        check({tag, "_stall_busy"}, stall, 1);
        check({tag, "_hi_held"}, hi, m_hi);
        check({tag, "_lo_held"}, lo, m_lo);
        issue = 1'b0;
      end
      step();
      if (c <= W + 1 && !busy) busy_ok = 1'b0;
      if (done) begin
        n_done++;
        done_at = c;
        check({tag, "_hi"}, hi, exp[2*W-1:W]);
        check({tag, "_lo"}, lo, exp[W-1:0]);
        func = F_MFHI; issue = 1'b1; #1;
        check({tag, "_stall_done"}, stall, 1);
        issue = 1'b0;
      end
    end
    check({tag, "_busy_held"}, busy_ok, 1);
    check({tag, "_done_cycle"}, done_at, W + 1);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_end"}, busy, 0);
    func = F_MFLO; issue = 1'b1; #1;
    check({tag, "_mflo_nostall"}, stall, 0);
    check({tag, "_mflo_ctrl"}, alu_ctrl, 4'b1011);
    issue = 1'b0;
    m_hi = exp[2*W-1:W];
    m_lo = exp[W-1:0];
  endtask

  initial begin
    int saw_done;
    reset = 1'b1; issue = 1'b0; alu_op = 2'b00; func = 6'b0; op_a = '0; op_b = '0;
    m_hi = '0; m_lo = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);

    foreach (dv[i]) begin
      alu_op = dv[i].op; func = dv[i].f; issue = 1'b1; #1;
      check($sformatf("dec%0d_ctrl", i), alu_ctrl, dv[i].ctrl);
      check($sformatf("dec%0d_illegal", i), illegal, dv[i].ill);
      check($sformatf("dec%0d_stall", i), stall, 0);
      step();
    end
    alu_op = 2'b10; func = 6'b111111; issue = 1'b0; #1;
    check("dec_noissue_illegal", illegal, 0);
    check("dec_sweep_busy", busy, 0);

    run_muldiv("multu_ff", F_MULTU, 8'hFF, 8'hFF, 16'hFE01);
    run_muldiv("divu_200_7", F_DIVU, 8'd200, 8'd7, 16'h041C);
    run_muldiv("divu_5_0", F_DIVU, 8'd5, 8'd0, 16'h05FF);
    run_muldiv("multu_80_02", F_MULTU, 8'h80, 8'h02, 16'h0100);
    run_muldiv("divu_ff_ff", F_DIVU, 8'hFF, 8'hFF, 16'h0001);

    alu_op = 2'b10; func = F_MTHI; op_a = 8'h3C; issue = 1'b1; #1;
    check("mthi_stall", stall, 0);
    step();
    issue = 1'b0;
    check("mthi_hi", hi, 8'h3C);
    check("mthi_lo_kept", lo, m_lo);
    check("mthi_busy", busy, 0);
    func = F_MTLO; op_a = 8'hA5; issue = 1'b1;
    step();
    issue = 1'b0;
    check("mtlo_lo", lo, 8'hA5);
    check("mtlo_hi_kept", hi, 8'h3C);
    m_hi = 8'h3C; m_lo = 8'hA5;

    alu_op = 2'b10; func = F_MULTU; op_a = 8'hFF; op_b = 8'hFF; issue = 1'b1;
    step();
    issue = 1'b0;
    repeat (4) step();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    saw_done = 0;
    for (int c = 0; c < W + 4; c++) begin
      step();
      if (done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_idle", busy, 0);
    m_hi = '0; m_lo = '0;
    run_muldiv("multu_3_4", F_MULTU, 8'd3, 8'd4, 16'h000C);

`ifdef SIGNED_MULDIV_EN
    run_muldiv("mult_m3_5", F_MULT, 8'hFD, 8'h05, 16'hFFF1);
    run_muldiv("div_m7_2", F_DIV, 8'hF9, 8'h02, 16'hFFFD);
`else
    alu_op = 2'b10; func = F_MULT; op_a = 8'hFD; op_b = 8'h05; issue = 1'b1; #1;
    check("mult_off_illegal", illegal, 1);
    check("mult_off_ctrl", alu_ctrl, 4'b1111);
    step();
    func = F_DIV; #1;
    check("div_off_illegal", illegal, 1);
    step();
    issue = 1'b0;
    check("mult_off_busy", busy, 0);
    saw_done = 0;
    for (int c = 0; c < W + 3; c++) begin
      step();
      if (done || busy) saw_done++;
    end
    check("mult_off_no_start", saw_done, 0);
    check("mult_off_hi", hi, m_hi);
    check("mult_off_lo", lo, m_lo);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
